// File: rtl/ab_seq_checker.sv
// Checks the "a, then b within [MIN_DLY, MAX_DLY] cycles" handshake and emits registered
// one-cycle pass/fail verdicts plus saturating pass/fail counters.
module ab_seq_checker #(
    parameter int unsigned MIN_DLY = 1,
    parameter int unsigned MAX_DLY = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             a,
    input  logic             b,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam int unsigned KW = $clog2(MAX_DLY + 1);
    localparam logic [KW-1:0] MinK = KW'(MIN_DLY);
    localparam logic [KW-1:0] MaxK = KW'(MAX_DLY);
    localparam logic [CNT_W-1:0] CntMax = '1;

    if (MIN_DLY == 0 || MIN_DLY > MAX_DLY || MAX_DLY > 65535 || CNT_W == 0) begin : gen_param_err
        $error("ab_seq_checker: need 1 <= MIN_DLY <= MAX_DLY <= 65535 and CNT_W >= 1");
    end

    typedef enum logic {StIdle, StWait} state_e;

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        pass_d     = 1'b0;
        fail_d     = 1'b0;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;

        if (clr) begin
            state_d    = StIdle;
            k_d        = '0;
            pass_cnt_d = '0;
            fail_cnt_d = '0;
        end else if (!en) begin
            // Disabling mid-check drops it without a verdict.
            state_d = StIdle;
            k_d     = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (a) begin
                        state_d = StWait;
                        k_d     = KW'(1);
                    end
                end
                StWait: begin
                    if (b) begin
                        if (k_q < MinK) fail_d = 1'b1;
                        else            pass_d = 1'b1;
                        state_d = StIdle;
                        k_d     = '0;
                    end else if (k_q == MaxK) begin
                        fail_d  = 1'b1;
                        state_d = StIdle;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    k_d     = '0;
                end
            endcase
        end

        if (pass_d && pass_cnt_d != CntMax) pass_cnt_d = pass_cnt_d + CNT_W'(1);
        if (fail_d && fail_cnt_d != CntMax) fail_cnt_d = fail_cnt_d + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            k_q        <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign busy     = (state_q == StWait);
    assign pass     = pass_q;
    assign fail     = fail_q;
    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_ab_seq_checker.sv
// Directed bench for ab_seq_checker: a default instance, one with MIN_DLY=2 and one with
// CNT_W=2, all driven by the same stimulus.
module tb_ab_seq_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en, clr, a, b;
    logic busy0, pass0, fail0;
    logic [7:0] pc0, fc0;
    logic busy1, pass1, fail1;
    logic [7:0] pc1, fc1;
    logic busy2, pass2, fail2;
    logic [1:0] pc2, fc2;

    int errors = 0;
    int checks = 0;

    ab_seq_checker #(.MIN_DLY(1), .MAX_DLY(4), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
        .busy(busy0), .pass(pass0), .fail(fail0), .pass_cnt(pc0), .fail_cnt(fc0)
    );
    ab_seq_checker #(.MIN_DLY(2), .MAX_DLY(4), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
        .busy(busy1), .pass(pass1), .fail(fail1), .pass_cnt(pc1), .fail_cnt(fc1)
    );
    ab_seq_checker #(.MIN_DLY(1), .MAX_DLY(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b),
        .busy(busy2), .pass(pass2), .fail(fail2), .pass_cnt(pc2), .fail_cnt(fc2)
    );

    typedef struct {
        logic en, clr, a, b;
        logic busy, pass, fail;
        int   pc, fc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic e, input logic c, input logic aa, input logic bb,
                       input logic bu, input logic p, input logic f, input int pc, input int fc);
        vec_t v;
        v.en = e; v.clr = c; v.a = aa; v.b = bb;
        v.busy = bu; v.pass = p; v.fail = f; v.pc = pc; v.fc = fc;
        vecs.push_back(v);
    endtask

    // Called at a negedge; returns at the following negedge with outputs settled.
    task automatic step(input logic e, input logic c, input logic aa, input logic bb);
        en = e; clr = c; a = aa; b = bb;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; a = 1'b0; b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst busy", 32'(busy0), 0);
        check("rst pass", 32'(pass0), 0);
        check("rst fail", 32'(fail0), 0);
        check("rst pass_cnt", 32'(pc0), 0);
        check("rst fail_cnt", 32'(fc0), 0);
        rst_n = 1'b1;

        //  en clr a  b   busy pass fail pc fc
        add(1, 0, 1, 0,   1, 0, 0, 0, 0);   // pass at k=1
        add(1, 0, 0, 1,   0, 1, 0, 1, 0);
        add(1, 0, 0, 0,   0, 0, 0, 1, 0);
        add(1, 0, 1, 0,   1, 0, 0, 1, 0);   // timeout
        add(1, 0, 0, 0,   1, 0, 0, 1, 0);
        add(1, 0, 0, 0,   1, 0, 0, 1, 0);
        add(1, 0, 0, 0,   1, 0, 0, 1, 0);
        add(1, 0, 0, 0,   0, 0, 1, 1, 1);
        add(1, 0, 0, 1,   0, 0, 0, 1, 1);   // late b ignored
        add(1, 0, 1, 0,   1, 0, 0, 1, 1);   // repeated a ignored in WAIT
        add(1, 0, 1, 0,   1, 0, 0, 1, 1);
        add(1, 0, 1, 0,   1, 0, 0, 1, 1);
        add(1, 0, 0, 1,   0, 1, 0, 2, 1);
        add(1, 0, 1, 1,   1, 0, 0, 2, 1);   // a=b=1 in IDLE: starts, no verdict
        add(0, 0, 0, 0,   0, 0, 0, 2, 1);   // en low aborts silently
        add(1, 0, 1, 0,   1, 0, 0, 2, 1);
        add(1, 0, 1, 1,   0, 1, 0, 3, 1);   // a on decision edge ignored
        add(1, 0, 0, 0,   0, 0, 0, 3, 1);
        add(1, 0, 0, 1,   0, 0, 0, 3, 1);   // b in IDLE ignored
        add(1, 0, 1, 0,   1, 0, 0, 3, 1);   // pass at k=MAX_DLY
        add(1, 0, 0, 0,   1, 0, 0, 3, 1);
        add(1, 0, 0, 0,   1, 0, 0, 3, 1);
        add(1, 0, 0, 0,   1, 0, 0, 3, 1);
        add(1, 0, 0, 1,   0, 1, 0, 4, 1);
        add(1, 1, 0, 0,   0, 0, 0, 0, 0);   // clr
        add(0, 0, 1, 0,   0, 0, 0, 0, 0);   // a with en low
        add(1, 0, 1, 0,   1, 0, 0, 0, 0);
        add(1, 1, 0, 1,   0, 0, 0, 0, 0);   // clr beats a deciding b

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].clr, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d busy", i), 32'(busy0), 32'(vecs[i].busy));
            check($sformatf("vec%0d pass", i), 32'(pass0), 32'(vecs[i].pass));
            check($sformatf("vec%0d fail", i), 32'(fail0), 32'(vecs[i].fail));
            check($sformatf("vec%0d pass_cnt", i), 32'(pc0), vecs[i].pc);
            check($sformatf("vec%0d fail_cnt", i), 32'(fc0), vecs[i].fc);
        end

        // MIN_DLY=2: b at k=1 is early, b at k=2 passes.
        step(1, 1, 0, 0);
        step(1, 0, 1, 0);
        check("min2 busy", 32'(busy1), 1);
        step(1, 0, 0, 1);
        check("min2 early fail", 32'(fail1), 1);
        check("min2 early pass", 32'(pass1), 0);
        check("min2 early busy", 32'(busy1), 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        step(1, 0, 0, 0);
        check("min2 k2 busy", 32'(busy1), 1);
        step(1, 0, 0, 1);
        check("min2 ok pass", 32'(pass1), 1);
        check("min2 ok fail", 32'(fail1), 0);
        check("min2 pass_cnt", 32'(pc1), 1);
        check("min2 fail_cnt", 32'(fc1), 1);

        // CNT_W=2: pass counter saturates at 3.
        step(1, 1, 0, 0);
        for (int n = 1; n <= 5; n++) begin
            step(1, 0, 1, 0);
            step(1, 0, 0, 1);
            check($sformatf("sat pass%0d", n), 32'(pass2), 1);
            check($sformatf("sat cnt%0d", n), 32'(pc2), (n > 3) ? 3 : n);
        end
        step(1, 1, 0, 0);
        check("sat clr cnt", 32'(pc2), 0);
        check("sat clr fail_cnt", 32'(fc2), 0);

        // Asynchronous reset while waiting at k=2.
        step(1, 0, 1, 0);
        step(1, 0, 0, 1);
        step(1, 0, 1, 0);
        step(1, 0, 0, 0);
        check("pre-rst busy", 32'(busy0), 1);
        check("pre-rst pass_cnt", 32'(pc0), 1);
        rst_n = 1'b0;
        #1;
        check("async rst busy", 32'(busy0), 0);
        check("async rst pass", 32'(pass0), 0);
        check("async rst fail", 32'(fail0), 0);
        check("async rst pass_cnt", 32'(pc0), 0);
        en = 1'b1; b = 1'b1;
        @(negedge clk);
        check("held rst fail", 32'(fail0), 0);
        check("held rst pass", 32'(pass0), 0);
        rst_n = 1'b1;
        step(1, 0, 0, 1);
        check("post-rst b pass", 32'(pass0), 0);
        check("post-rst b busy", 32'(busy0), 0);

        // Reset drops a live pass pulse immediately.
        step(1, 0, 1, 0);
        step(1, 0, 0, 1);
        check("pulse pre-rst", 32'(pass0), 1);
        rst_n = 1'b0;
        #1;
        check("pulse async rst", 32'(pass0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
